// File: rtl/mips_isa_pkg.sv
// MIPS instruction-set constants, command kinds and loader states shared by
// the encoder, the loader top and the testbench reference values.
package mips_isa_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    // Compact command kinds; codes 14 and 15 are illegal
    typedef enum logic [3:0] {
        KIND_ADD  = 4'd0,
        KIND_SUB  = 4'd1,
        KIND_AND  = 4'd2,
        KIND_OR   = 4'd3,
        KIND_SLT  = 4'd4,
        KIND_JR   = 4'd5,
        KIND_ADDI = 4'd6,
        KIND_LW   = 4'd7,
        KIND_SW   = 4'd8,
        KIND_BEQ  = 4'd9,
        KIND_BNE  = 4'd10,
        KIND_J    = 4'd11,
        KIND_JAL  = 4'd12,
        KIND_NOP  = 4'd13
    } cmd_kind_e;

    // Loader control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PAD  = 2'd2,
        S_DONE = 2'd3
    } load_state_e;

    // R-type word: shamt is always zero for the supported instructions
    function automatic logic [31:0] r_type(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [5:0] funct);
        return {OP_R, rs, rt, rd, 5'd0, funct};
    endfunction

    // I-type word
    function automatic logic [31:0] i_type(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // J-type word
    function automatic logic [31:0] j_type(input logic [5:0]  op,
                                           input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_field_encode.sv
// Purely combinational translation of a command kind plus its fields into a
// 32-bit MIPS word, flagging the unused kind codes as illegal.
module instr_field_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Select the instruction format and opcode/funct for the requested kind
    always_comb begin
        word_o    = 32'h0000_0000;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_ADD:  word_o = r_type(rs_i, rt_i, rd_i, FUNCT_ADD);
            KIND_SUB:  word_o = r_type(rs_i, rt_i, rd_i, FUNCT_SUB);
            KIND_AND:  word_o = r_type(rs_i, rt_i, rd_i, FUNCT_AND);
            KIND_OR:   word_o = r_type(rs_i, rt_i, rd_i, FUNCT_OR);
            KIND_SLT:  word_o = r_type(rs_i, rt_i, rd_i, FUNCT_SLT);
            KIND_JR:   word_o = r_type(rs_i, 5'd0, 5'd0, FUNCT_JR);
            KIND_ADDI: word_o = i_type(OP_ADDI, rs_i, rt_i, imm_i);
            KIND_LW:   word_o = i_type(OP_LW,   rs_i, rt_i, imm_i);
            KIND_SW:   word_o = i_type(OP_SW,   rs_i, rt_i, imm_i);
            KIND_BEQ:  word_o = i_type(OP_BEQ,  rs_i, rt_i, imm_i);
            KIND_BNE:  word_o = i_type(OP_BNE,  rs_i, rt_i, imm_i);
            KIND_J:    word_o = j_type(OP_J,   target_i);
            KIND_JAL:  word_o = j_type(OP_JAL, target_i);
            KIND_NOP:  word_o = 32'h0000_0000;
            default: begin
                word_o    = 32'h0000_0000;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts compact instruction commands, encodes them and streams the words
// into instruction memory from address 0, then appends a run of NOP words.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int IMEM_WORDS = 1024,
    parameter int PAD_NOPS   = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    // Capacity and pad length expressed at counter width
    localparam logic [ADDR_W:0] CAP     = (ADDR_W+1)'(IMEM_WORDS);
    localparam logic [ADDR_W:0] PAD_LIM = (ADDR_W+1)'(PAD_NOPS);

    load_state_e       state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   pad_q, pad_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              ready_c;

    logic [31:0]       enc_word;
    logic              enc_illegal;

    instr_field_encode u_encode (
        .kind_i    (cmd_kind),
        .rs_i      (cmd_rs),
        .rt_i      (cmd_rt),
        .rd_i      (cmd_rd),
        .imm_i     (cmd_imm),
        .target_i  (cmd_target),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // Next-state, write-request and handshake logic for the load sequence
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pad_d   = pad_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        ready_c = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    pad_d   = '0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end

            S_LOAD: begin
                ready_c = (count_q < CAP);
                if (cmd_valid && ready_c) begin
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                        count_d = count_q + 1'b1;
                    end
                    if (cmd_last) begin
                        pad_d   = '0;
                        state_d = (PAD_LIM == '0) ? S_DONE : S_PAD;
                    end
                end else if (cmd_valid) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_PAD: begin
                if ((pad_q < PAD_LIM) && (count_q < CAP)) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = 32'h0000_0000;
                    count_d = count_q + 1'b1;
                    pad_d   = pad_q + 1'b1;
                    if ((pad_q + 1'b1 == PAD_LIM) || (count_q + 1'b1 == CAP)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Register state and the write port; reset drops any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pad_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pad_q   <= pad_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready  = ready_c;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_PAD);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign word_count = count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder counterpart to the processor's opcode/funct control decoder. It accepts compact instruction commands (kind, register fields, immediate/target) over a valid/ready handshake, encodes each into a 32-bit MIPS word, and writes it sequentially into instruction memory from address 0. It sits between the testbench/boot loader and the IMEM write port, and is used to load programs before the single-cycle core is released.

Parameters:
ADDR_W, 10, IMEM word-address width.
IMEM_WORDS, 1024, capacity in words; must be ≤ 2**ADDR_W.
PAD_NOPS, 4, number of zero words appended after the last command.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a load at address 0
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 J, 12 JAL, 13 NOP, 14-15 illegal
cmd_rs / cmd_rt / cmd_rd  in  5 each  register fields
cmd_imm  in  16  I-type immediate
cmd_target  in  26  J-type target
cmd_last  in  1  marks final command
imem_we  out  1  IMEM write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded word
busy  out  1  high in LOAD or PAD
done  out  1  high in DONE
err  out  1  sticky: illegal kind or overflow
word_count  out  ADDR_W+1  words written in current load

Behaviour:
- Reset: state IDLE; cmd_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, word_count = 0.
- Encoding:
  - R-type (kinds 0-4): opcode 0; rs, rt, rd; shamt 0; funct 0x20/0x22/0x24/0x25/0x2A.
  - JR: opcode 0, rs, all other fields 0, funct 0x08.
  - I-type: opcode 0x08/0x23/0x2B/0x04/0x05 with {rs, rt, imm}.
  - J/JAL: opcode 0x02/0x03 with target.
  - NOP: 0x00000000.
- FSM IDLE -> LOAD:
  - Taken on start in IDLE or DONE.
  - Clears the address counter, word_count and err.
  - start in LOAD or PAD is ignored.
- LOAD:
  - cmd_ready = 1 while word_count < IMEM_WORDS.
  - A handshake in cycle N produces registered imem_we = 1, imem_addr = word_count, imem_wdata = encoding in cycle N+1; word_count increments in the same cycle. One-cycle latency; back-to-back accepts yield back-to-back writes.
  - Illegal kind: the command is accepted and consumed, no write occurs, err is set, and the FSM stays in LOAD (cmd_last still honoured).
  - Accepting cmd_last moves the FSM to PAD.
  - Overflow: if cmd_valid is high while word_count == IMEM_WORDS, set err, keep cmd_ready low, and go to DONE.
- PAD:
  - cmd_ready = 0.
  - Emits PAD_NOPS consecutive zero-word writes at successive addresses, then goes to DONE.
  - If capacity is reached mid-pad, padding is truncated silently (no err) and the FSM goes to DONE.
  - PAD_NOPS = 0 goes straight to DONE.
- DONE: done = 1, imem_we = 0; holds until start.
- Address never wraps; word_count saturates at IMEM_WORDS.
- imem_we is a single-cycle pulse per word and is never asserted in IDLE or DONE, except for the final registered write, which lands in the first cycle of the next state.
- Reset mid-operation: at the next edge all outputs take reset values; a pending registered write is dropped.

Decomposition:
- mips_isa_pkg holds:
  - opcode constants (R 0x00, ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03);
  - funct constants (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, JR 0x08);
  - the cmd_kind enum and the FSM state enum.
- Sub-module instr_field_encode: purely combinational kind+fields -> {word, illegal}. It can be reused by the bench's reference model.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 -> one cycle later imem_we=1, addr 0, wdata 0x00221820.
- ADDI rs=0 rt=8 imm=5, then LW rs=29 rt=9 imm=4, back-to-back -> writes 0x20080005 @0 and 0x8FA90004 @1 in consecutive cycles.
- BEQ rs=1 rt=2 imm=0xFFFF; JAL target=0x100000; JR rs=31 with cmd_last (PAD_NOPS=4):
  - writes 0x1022FFFF, 0x0C100000, 0x03E00008, then four 0x00000000 @3..6;
  - done=1, word_count=7.
- kind=14 between two NOPs -> only 2 writes, err=1 sticky until the next start.
- IMEM_WORDS=4, six commands without cmd_last -> 4 writes, cmd_ready drops, err=1, done=1.
- rst asserted one cycle after a handshake -> no imem_we the following cycle, all outputs zero, state IDLE.
